weight_fifo_seq: RTL and testbench
==================================

WEIGHT_FIFO_SEQ -- requirements
Module: weight_fifo_seq

Interface
REQ-001 SHALL have parameter COLS, default 4, the number of column weight FIFOs it sequences.
REQ-002 SHALL have parameter DEPTH, default 8, the per-column FIFO depth; usable capacity is DEPTH-1 entries.
REQ-003 SHALL have parameter ADDR_W, default 8, the weight memory address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle job request.
REQ-007 SHALL have port base_addr, input, ADDR_W bits: first weight address, sampled on an accepted start.
REQ-008 SHALL have port rows, input, $clog2(DEPTH)+1 bits: weights per column, sampled on an accepted start.
REQ-009 SHALL have port hold, input, 1 bit: drain stall from the array.
REQ-010 SHALL have port fifo_empty, input, COLS bits: per-column FIFO empty flags.
REQ-011 SHALL have port mem_rd, output, 1 bit: weight memory read strobe; data returns exactly 1 cycle later.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: read address.
REQ-013 SHALL have port fifo_w_en, output, COLS bits: one-hot FIFO write enables; memory data is broadcast to all FIFOs externally.
REQ-014 SHALL have port fifo_r_en, output, COLS bits: per-column FIFO read enables.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-017 SHALL have port err, output, 1 bit: one-cycle rejected-start pulse.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, FLUSH, DRAIN and DONE.
REQ-019 SHALL accept start only in IDLE, and only when 1 <= rows <= DEPTH-1 and fifo_empty is all ones; otherwise it SHALL pulse err on the next cycle and remain in IDLE.
REQ-020 SHALL ignore start in every state other than IDLE, with no err pulse.
REQ-021 On an accepted start in cycle N, SHALL enter LOAD in cycle N+1.
REQ-022 In LOAD, SHALL assert mem_rd on every cycle for exactly COLS*rows cycles.
REQ-023 In LOAD, addresses SHALL be base_addr+0, +1, ... in column-major order: column c, row r maps to offset c*rows+r.
REQ-024 mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-025 SHALL assert fifo_w_en[c] one cycle after each mem_rd issued for column c, and SHALL never assert more than one bit at a time.
REQ-026 After the last read, SHALL spend exactly 1 cycle in FLUSH, which carries the final write, then enter DRAIN.
REQ-027 In DRAIN, SHALL maintain a counter t starting at 0; fifo_r_en[c] SHALL be high iff c <= t < c+rows and fifo_empty[c]=0 and hold=0.
REQ-028 While hold=1, t SHALL freeze and all fifo_r_en SHALL be 0.
REQ-029 DRAIN SHALL last rows+COLS-1 unheld cycles, then DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-030 mem_rd, mem_addr, fifo_r_en, busy and done SHALL be decoded from registered state only (Moore outputs); no input SHALL combinationally reach any output except the hold and fifo_empty gating of fifo_r_en.
REQ-031 When fifo_empty[c]=1 inside its drain window, SHALL suppress fifo_r_en[c] without stalling t; this is an error case and no retry SHALL occur.

Reset
REQ-032 When rstn=0, SHALL asynchronously force state=IDLE, clear all counters, and hold every output (mem_rd, mem_addr, fifo_w_en, fifo_r_en, busy, done, err) at 0.
REQ-033 On reset mid-job, SHALL abandon the job with no done pulse and SHALL be ready to accept start on the first cycle after rstn rises.

Structure
REQ-034 The FSM state enum and the default COLS/DEPTH values SHALL be defined in the shared package spiketpu_pkg.
REQ-035 The drain-window comparator SHALL be a sub-module skew_window_gen, instantiated once and producing the COLS-bit window mask from t and rows.

Verification
REQ-036 Bench SHALL cover: COLS=4, rows=3, base_addr=0x10, start at cycle 0 -> 12 reads at 0x10..0x1B in cycles 1-12; fifo_w_en one-hot in cycles 2-13; DRAIN in cycles 14-19; done in cycle 20; busy high in cycles 1-20.
REQ-037 Bench SHALL cover: in the REQ-036 DRAIN -> fifo_r_en = 0001, 0011, 0111, 1110, 1100, 1000 on consecutive cycles.
REQ-038 Bench SHALL cover: rows=0, rows=8 (DEPTH=8), or fifo_empty=1011 at start -> err pulse 1 cycle later, busy stays 0, no mem_rd.
REQ-039 Bench SHALL cover: base_addr=0xFE, rows=2 -> addresses 0xFE, 0xFF, 0x00, 0x01, ...
REQ-040 Bench SHALL cover: hold=1 for 3 cycles at DRAIN t=2 -> fifo_r_en all 0 for those cycles, done delayed by exactly 3 cycles.
REQ-041 Bench SHALL cover: rstn low during LOAD, and start pulsed during DRAIN -> outputs 0 immediately and no done; mid-DRAIN start ignored, with no err.

Source files
------------

// File: rtl/spiketpu_pkg.sv
// Shared definitions for the spiketpu weight path.
//   state_e       : weight sequencer FSM states
//   COLS_DEF      : default number of column weight FIFOs
//   DEPTH_DEF     : default per-column FIFO depth (usable capacity DEPTH-1)
package spiketpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int COLS_DEF  = 4;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/skew_window_gen.sv
// Skewed drain-window mask: column c is open while c <= t < c+rows, so
// successive columns start one cycle apart (systolic skew).
//   t    : drain step counter
//   rows : weights per column
//   win  : per-column window-open mask
module skew_window_gen #(
  parameter int COLS = 4,
  parameter int T_W  = 5,
  parameter int R_W  = 4
) (
  input  logic [T_W-1:0]  t,
  input  logic [R_W-1:0]  rows,
  output logic [COLS-1:0] win
);

  // One spare bit so c+rows never overflows.
  localparam int W = ((T_W > R_W) ? T_W : R_W) + 1;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [W-1:0] LO = W'(c);
    assign win[c] = (W'(t) >= LO) && (W'(t) < LO + W'(rows));
  end

endmodule

// File: rtl/weight_fifo_seq.sv
// Weight FIFO sequencer: loads COLS*rows weights from memory column-major
// into per-column FIFOs, then drains them with a one-cycle skew per column.
//   clk, rstn      : clock, async active-low reset
//   start          : job request (IDLE only), samples base_addr / rows
//   hold           : drain stall from the array
//   fifo_empty     : per-column FIFO empty flags
//   mem_rd/mem_addr: weight read strobe/address (data 1 cycle later)
//   fifo_w_en      : one-hot FIFO write enable, aligned with returned data
//   fifo_r_en      : per-column FIFO read enable during DRAIN
//   busy/done/err  : not-IDLE, job-complete pulse, rejected-start pulse
module weight_fifo_seq
  import spiketpu_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [$clog2(DEPTH):0]   rows,
  input  logic                     hold,
  input  logic [COLS-1:0]          fifo_empty,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [COLS-1:0]          fifo_w_en,
  output logic [COLS-1:0]          fifo_r_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int R_W = $clog2(DEPTH) + 1;
  localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int T_W = $clog2(DEPTH + COLS) + 1;

  state_e            state, nxt;
  logic [R_W-1:0]    rows_q;
  logic [ADDR_W-1:0] addr_q;
  logic [R_W-1:0]    row_q;
  logic [C_W-1:0]    col_q;
  logic [T_W-1:0]    t_q;
  logic [COLS-1:0]   w_en_q;
  logic              err_q;
  logic [COLS-1:0]   win;
  logic              accept, last_rd, last_drain;

  assign accept     = (state == IDLE) && start && (rows != '0) &&
                      (rows <= R_W'(DEPTH - 1)) && (&fifo_empty);
  assign last_rd    = (col_q == C_W'(COLS - 1)) && (row_q + R_W'(1) == rows_q);
  assign last_drain = (t_q + T_W'(1)) == (T_W'(rows_q) + T_W'(COLS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = LOAD;
      LOAD:    if (last_rd) nxt = FLUSH;
      FLUSH:   nxt = DRAIN;
      DRAIN:   if (!hold && last_drain) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q <= '0;
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      t_q    <= '0;
      w_en_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !accept;
      // Write enable trails the read by one cycle, steered by the read's column.
      w_en_q <= (state == LOAD) ? (COLS'(1) << col_q) : '0;
      if (accept) begin
        rows_q <= rows;
        addr_q <= base_addr;
        row_q  <= '0;
        col_q  <= '0;
      end else if (state == LOAD) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (row_q + R_W'(1) == rows_q) begin
          row_q <= '0;
          col_q <= col_q + C_W'(1);
        end else begin
          row_q <= row_q + R_W'(1);
        end
      end
      if (state != DRAIN) t_q <= '0;
      else if (!hold)     t_q <= t_q + T_W'(1);
    end
  end

  skew_window_gen #(.COLS(COLS), .T_W(T_W), .R_W(R_W)) u_win (
    .t    (t_q),
    .rows (rows_q),
    .win  (win)
  );

  assign mem_rd    = (state == LOAD);
  assign mem_addr  = (state == LOAD) ? addr_q : '0;
  assign fifo_w_en = w_en_q;
  // Empty columns are skipped without stalling t; the missed weight is lost.
  assign fifo_r_en = (state == DRAIN && !hold) ? (win & ~fifo_empty) : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_weight_fifo_seq.sv
module tb_weight_fifo_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] base_addr;
  logic [3:0] rows;
  logic       hold;
  logic [3:0] fifo_empty;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [3:0] fifo_w_en;
  logic [3:0] fifo_r_en;
  logic       busy, done, err;

  int checks = 0;
  int fails  = 0;

  weight_fifo_seq #(.COLS(4), .DEPTH(8), .ADDR_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .rows(rows),
    .hold(hold), .fifo_empty(fifo_empty), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .fifo_w_en(fifo_w_en), .fifo_r_en(fifo_r_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One entry per cycle: stimulus to drive plus outputs expected in that cycle.
  typedef struct {
    logic       st;
    logic       hd;
    logic [3:0] fe;
    logic       rd;
    logic [7:0] addr;
    logic [3:0] wen;
    logic [3:0] ren;
    logic       bsy;
    logic       dn;
    logic       er;
  } ent_t;

  ent_t q[$];

  function automatic ent_t idle_ent();
    ent_t e;
    e.st = 1'b0; e.hd = 1'b0; e.fe = 4'hF; e.rd = 1'b0; e.addr = 8'h00;
    e.wen = 4'h0; e.ren = 4'h0; e.bsy = 1'b0; e.dn = 1'b0; e.er = 1'b0;
    return e;
  endfunction

  // Expected cycle trace of one job, starting with the start cycle.
  task automatic build(input int r, input logic [7:0] b, input logic [3:0] fe0,
                       input int hold_t, input int hold_n, input logic [3:0] demp,
                       input int dstart_t);
    ent_t e;
    int   t, h;
    e = idle_ent(); e.st = 1'b1; e.fe = fe0; q.push_back(e);
    if (!(r >= 1 && r <= 7 && fe0 == 4'hF)) begin
      e = idle_ent(); e.er = 1'b1; q.push_back(e);
      e = idle_ent(); q.push_back(e);
      return;
    end
    for (int i = 0; i < 4 * r; i++) begin
      e = idle_ent(); e.rd = 1'b1; e.addr = b + 8'(i); e.bsy = 1'b1;
      if (i > 0) e.wen = 4'(1) << ((i - 1) / r);
      q.push_back(e);
    end
    e = idle_ent(); e.bsy = 1'b1; e.wen = 4'b1000; e.fe = demp; q.push_back(e);
    t = 0; h = 0;
    while (t < r + 3) begin
      e = idle_ent(); e.bsy = 1'b1; e.fe = demp;
      if (t == dstart_t) e.st = 1'b1;
      if (t == hold_t && h < hold_n) begin
        e.hd = 1'b1; h++;
      end else begin
        for (int c = 0; c < 4; c++)
          if (c <= t && t < c + r && !demp[c]) e.ren[c] = 1'b1;
        t++;
      end
      q.push_back(e);
    end
    e = idle_ent(); e.bsy = 1'b1; e.dn = 1'b1; e.fe = demp; q.push_back(e);
    e = idle_ent(); q.push_back(e);
  endtask

  task automatic run(input string tag, input int n);
    ent_t e;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      @(posedge clk); #1;
      start = e.st; hold = e.hd; fifo_empty = e.fe;
      #3;
      checks++;
      assert ({mem_rd, mem_addr, fifo_w_en, fifo_r_en, busy, done, err} ===
              {e.rd, e.addr, e.wen, e.ren, e.bsy, e.dn, e.er})
      else begin
        fails++;
        $error("FAIL %s cyc%0d got rd=%b a=%h w=%b r=%b b=%b d=%b e=%b exp rd=%b a=%h w=%b r=%b b=%b d=%b e=%b",
               tag, k, mem_rd, mem_addr, fifo_w_en, fifo_r_en, busy, done, err,
               e.rd, e.addr, e.wen, e.ren, e.bsy, e.dn, e.er);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({mem_rd, mem_addr, fifo_w_en, fifo_r_en, busy, done, err} === 23'd0)
    else begin
      fails++;
      $error("FAIL %s got rd=%b a=%h w=%b r=%b b=%b d=%b e=%b exp all 0",
             tag, mem_rd, mem_addr, fifo_w_en, fifo_r_en, busy, done, err);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b1; hold = 1'b0; fifo_empty = 4'hF;
    base_addr = 8'h10; rows = 4'd3;
    #12 check_zero("reset");
    start = 1'b0;
    #8 rstn = 1'b1;

    // Baseline job: 12 reads, skewed drain 0001..1000, done in cycle 20.
    base_addr = 8'h10; rows = 4'd3;
    build(3, 8'h10, 4'hF, -1, 0, 4'h0, -1); run("basic", 1000);

    // Rejected starts.
    rows = 4'd0; build(0, 8'h10, 4'hF, -1, 0, 4'h0, -1); run("rows0", 1000);
    rows = 4'd8; build(8, 8'h10, 4'hF, -1, 0, 4'h0, -1); run("rows8", 1000);
    rows = 4'd3; build(3, 8'h10, 4'b1011, -1, 0, 4'h0, -1); run("notempty", 1000);

    // Address wrap.
    base_addr = 8'hFE; rows = 4'd2;
    build(2, 8'hFE, 4'hF, -1, 0, 4'h0, -1); run("wrap", 1000);

    // Hold three cycles at t=2.
    base_addr = 8'h10; rows = 4'd3;
    build(3, 8'h10, 4'hF, 2, 3, 4'h0, -1); run("hold", 1000);

    // Column 2 unexpectedly empty during drain: suppressed, no stall.
    base_addr = 8'h30; rows = 4'd3;
    build(3, 8'h30, 4'hF, -1, 0, 4'b0100, -1); run("emptycol", 1000);

    // Start pulsed mid-drain is ignored.
    base_addr = 8'h50; rows = 4'd4;
    build(4, 8'h50, 4'hF, -1, 0, 4'h0, 2); run("drainstart", 1000);

    // Reset during LOAD, then a job accepted on the first cycle after release.
    base_addr = 8'h20; rows = 4'd3;
    build(3, 8'h20, 4'hF, -1, 0, 4'h0, -1); run("preload", 5);
    #2 rstn = 1'b0;
    #1 check_zero("rst_async");
    q.delete();
    start = 1'b1;
    @(posedge clk); #4 check_zero("rst_held");
    start = 1'b0;
    @(negedge clk); rstn = 1'b1;
    base_addr = 8'h40; rows = 4'd1;
    build(1, 8'h40, 4'hF, -1, 0, 4'h0, -1); run("postrst", 1000);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
